seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised, registered ALU with an iterative multiply/divide unit and HI/LO registers.
//  Sits in the EX stage of the pipelined CPU.
//  Single-cycle ops return a registered result one cycle after acceptance.
//  MULT/DIV ops occupy the unit for a fixed number of cycles and raise busy.
// PARAMETERS
//  WIDTH       32  datapath width; must be >= 8 and a power of two
//  MUL_CYCLES  5   cycles busy is high for MULT/MULTU; must be >= 1
//  DIV_CYCLES  10  cycles busy is high for DIV/DIVU; must be >= 1
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  req_valid  in   1      request present on op/a/b
//  req_ready  out  1      = !busy; a request is accepted on req_valid & req_ready
//  op         in   5      opcode, see BEHAVIOUR
//  a          in   WIDTH  operand 1
//  b          in   WIDTH  operand 2; shift amount = b[$clog2(WIDTH)-1:0]
//  result     out  WIDTH  registered single-cycle result
//  res_valid  out  1      1-cycle pulse: result/overflow are valid
//  overflow   out  1      signed overflow of ADD/SUB; 0 for other ops
//  busy       out  1      MD unit is computing
//  md_done    out  1      1-cycle pulse: hi/lo were just updated by MULT/DIV
//  div_zero   out  1      sticky until the next MD op starts: last DIV/DIVU had b==0
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  Reset values: result=0, res_valid=0, overflow=0, busy=0, md_done=0, div_zero=0, hi=0, lo=0.
//  Opcodes:
//   0 ADD, 1 SUB, 2 OR, 3 AND, 4 SLT, 5 SLTU, 6 XOR, 7 NOR, 8 SLL, 9 SRL, 10 SRA, 11 LUI
//   16 MULT, 17 MULTU, 18 DIV, 19 DIVU, 20 MTHI, 21 MTLO
//   Any other opcode is accepted: result=0, res_valid pulses, no other effect.
//  Single-cycle ops (0-11): accepted in cycle N -> result and res_valid at N+1.
//   ADD/SUB result = low WIDTH bits.
//   overflow = 1 when the (WIDTH+1)-bit sign-extended sum/difference has its top two bits different.
//   SLT/SLTU result = {0..0, flag}.
//   SRA replicates a[WIDTH-1].
//   LUI result = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
//   Back-to-back requests every cycle are legal while busy=0.
//  MTHI/MTLO: hi or lo <= a at N+1; res_valid stays 0; busy is not raised.
//  MULT/MULTU/DIV/DIVU accepted in cycle N:
//   busy is high from N+1 through N+L, where L = MUL_CYCLES or DIV_CYCLES.
//   hi/lo are written and md_done pulses at N+L; busy is 0 at N+L+1.
//   hi/lo hold their old values while busy.
//   Operands are latched at acceptance; changes to a/b during busy have no effect.
//   MULT: {hi,lo} = signed a*b (2*WIDTH bits). MULTU: unsigned.
//   DIV: lo = quotient truncated toward zero; hi = remainder, sign of the dividend. DIVU: unsigned.
//   b==0: lo = all ones, hi = a, div_zero=1.
//   Signed MIN/-1: lo = MIN, hi = 0, div_zero=0.
//   Starting any MD op clears div_zero.
//  While busy=1: req_ready=0 and every request, including MTHI/MTLO and single-cycle ops, is ignored.
//   The pipeline stalls on busy.
//  A request is accepted in the same cycle busy falls (N+L+1).
//  Reset mid-operation: busy, md_done and res_valid drop immediately (async); hi/lo=0; the op is discarded.
//  MD counter: down-counter loaded with L-1; no wrap; the done path fires when it reaches 0 while busy.
// STRUCTURE
//  Shared package alu_pkg:
//   - localparam opcodes listed above
//   - OP_W=5
//   - function is_md(op)
//  Sub-module md_unit (WIDTH, MUL_CYCLES, DIV_CYCLES):
//   - owns the operand latches, cycle counter, hi/lo, div_zero and md_done
//   - the multiply/divide may be computed combinationally at start and released after L cycles
//  seq_alu holds the single-cycle datapath, its output registers and the accept logic.
// TESTING (WIDTH=32, default latencies)
//  1 ADD a=32'h7FFF_FFFF b=1 -> next cycle result=32'h8000_0000, overflow=1, res_valid=1;
//    SUB a=32'h8000_0000 b=1 -> 32'h7FFF_FFFF, overflow=1.
//  2 MULT a=-3 b=7 -> busy for 5 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB, md_done 1 pulse;
//    MULTU with the same operands -> hi=6, lo=32'hFFFF_FFEB.
//  3 DIV a=-7 b=2 -> after 10 cycles lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF;
//    DIV a=5 b=0 -> lo=32'hFFFF_FFFF, hi=5, div_zero=1;
//    DIV a=32'h8000_0000 b=-1 -> lo=32'h8000_0000, hi=0.
//  4 Requests are ignored while busy:
//    ADD and MTLO presented every cycle during a DIV -> req_ready=0, no res_valid, lo holds its old value.
//    ADD presented at the cycle busy falls -> accepted.
//  5 Reset is asserted 3 cycles into a MULT -> busy=0, hi=lo=0 immediately.
//    After release, a new MULTU 2*3 gives lo=6 after 5 cycles.
//  6 SRA a=32'h8000_0000 b=31 -> 32'hFFFF_FFFF; LUI b=16'h1234 -> 32'h1234_0000;
//    SLTU a=1 b=-1 -> 1; SLT a=1 b=-1 -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: opcode encodings and opcode class helpers.
package alu_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
  localparam logic [OP_W-1:0] OP_OR    = 5'd2;
  localparam logic [OP_W-1:0] OP_AND   = 5'd3;
  localparam logic [OP_W-1:0] OP_SLT   = 5'd4;
  localparam logic [OP_W-1:0] OP_SLTU  = 5'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd6;
  localparam logic [OP_W-1:0] OP_NOR   = 5'd7;
  localparam logic [OP_W-1:0] OP_SLL   = 5'd8;
  localparam logic [OP_W-1:0] OP_SRL   = 5'd9;
  localparam logic [OP_W-1:0] OP_SRA   = 5'd10;
  localparam logic [OP_W-1:0] OP_LUI   = 5'd11;
  localparam logic [OP_W-1:0] OP_MULT  = 5'd16;
  localparam logic [OP_W-1:0] OP_MULTU = 5'd17;
  localparam logic [OP_W-1:0] OP_DIV   = 5'd18;
  localparam logic [OP_W-1:0] OP_DIVU  = 5'd19;
  localparam logic [OP_W-1:0] OP_MTHI  = 5'd20;
  localparam logic [OP_W-1:0] OP_MTLO  = 5'd21;

  // Multi-cycle multiply/divide ops that occupy the MD unit.
  function automatic logic is_md(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative-latency multiply/divide unit with HI/LO registers.
// The product/quotient is computed from the operands presented at start, held
// in pending registers, and released into HI/LO after the configured latency.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   start_i             begin an MD op (op_i/a_i/b_i sampled this cycle)
//   mthi_i, mtlo_i      write a_i into HI / LO
//   op_i, a_i, b_i      opcode and operands
//   busy_o              unit computing
//   md_done_o           1-cycle pulse when HI/LO take the new result
//   div_zero_o          last DIV/DIVU had a zero divisor (cleared on start)
//   hi_o, lo_o          HI/LO registers
module md_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             md_done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_L + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             md_done_q, md_done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;
  logic             fire;

  // Arithmetic on the operands presented at start.
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;
  logic [WIDTH-1:0]   calc_hi, calc_lo;
  logic               calc_dz;

  assign prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Signed divide via magnitudes; MIN/-1 falls out as quotient MIN, remainder 0.
  assign sgn     = (op_i == OP_DIV);
  assign a_neg   = sgn & a_i[WIDTH-1];
  assign b_neg   = sgn & b_i[WIDTH-1];
  assign a_mag   = a_neg ? -a_i : a_i;
  assign b_mag   = b_neg ? -b_i : b_i;
  assign divisor = (b_i == '0) ? WIDTH'(1) : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem     = a_neg ? -r_mag : r_mag;

  always_comb begin
    calc_hi = '0;
    calc_lo = '0;
    calc_dz = 1'b0;
    case (op_i)
      OP_MULT:  {calc_hi, calc_lo} = prod_s;
      OP_MULTU: {calc_hi, calc_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_i == '0) begin
          calc_hi = a_i;
          calc_lo = '1;
          calc_dz = 1'b1;
        end else begin
          calc_hi = rem;
          calc_lo = quot;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    md_done_d  = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_dz_d  = pend_dz_q;

    if (start_i) begin
      busy_d     = 1'b1;
      cnt_d      = is_div(op_i) ? DIV_LOAD : MUL_LOAD;
      pend_hi_d  = calc_hi;
      pend_lo_d  = calc_lo;
      pend_dz_d  = calc_dz;
      div_zero_d = 1'b0;
    end else if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - CNT_W'(1);
    end else begin
      if (mthi_i) hi_d = a_i;
      if (mtlo_i) lo_d = a_i;
    end

    // Counter reaching 0 while busy releases the result; with a latency of 1
    // this happens on the start edge itself, hence the use of pend_*_d.
    fire = busy_d && (cnt_d == '0);
    if (fire) begin
      hi_d       = pend_hi_d;
      lo_d       = pend_lo_d;
      div_zero_d = pend_dz_d;
      md_done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      md_done_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      pend_dz_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      md_done_q  <= md_done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_dz_q  <= pend_dz_d;
    end
  end

  assign busy_o     = busy_q;
  assign md_done_o  = md_done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: rtl/seq_alu.sv
// Registered EX-stage ALU: single-cycle datapath with output registers,
// request accept logic, and an attached multiply/divide unit owning HI/LO.
// Ports:
//   clk, reset              clock, async active-high reset
//   req_valid, req_ready    request handshake (req_ready = !busy)
//   op, a, b                opcode and operands
//   result, res_valid       registered single-cycle result and its 1-cycle valid
//   overflow                signed overflow of ADD/SUB
//   busy, md_done, div_zero MD unit status
//   hi, lo                  HI/LO registers
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             overflow,
  output logic             busy,
  output logic             md_done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic             accept, md_start, mthi, mtlo;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH:0]   ext_sum, ext_dif;
  logic             slt, sltu;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ov;
  logic [WIDTH-1:0] result_q, result_d;
  logic             res_valid_q, res_valid_d;
  logic             overflow_q, overflow_d;

  assign req_ready = ~busy;
  assign accept    = req_valid & req_ready;
  assign md_start  = accept & is_md(op);
  assign mthi      = accept & (op == OP_MTHI);
  assign mtlo      = accept & (op == OP_MTLO);

  assign shamt   = b[SH_W-1:0];
  assign ext_sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign ext_dif = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign slt     = $signed(a) < $signed(b);
  assign sltu    = a < b;

  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    case (op)
      OP_ADD:  begin alu_res = ext_sum[WIDTH-1:0]; alu_ov = ext_sum[WIDTH] ^ ext_sum[WIDTH-1]; end
      OP_SUB:  begin alu_res = ext_dif[WIDTH-1:0]; alu_ov = ext_dif[WIDTH] ^ ext_dif[WIDTH-1]; end
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu};
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: ;
    endcase
  end

  // Everything accepted except MD and MTHI/MTLO produces a result pulse;
  // result/overflow hold between pulses.
  always_comb begin
    res_valid_d = accept & ~is_md(op) & (op != OP_MTHI) & (op != OP_MTLO);
    result_d    = result_q;
    overflow_d  = overflow_q;
    if (res_valid_d) begin
      result_d   = alu_res;
      overflow_d = alu_ov;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      res_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign result    = result_q;
  assign res_valid = res_valid_q;
  assign overflow  = overflow_q;

  md_unit #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk_i      (clk),
    .rst_i      (reset),
    .start_i    (md_start),
    .mthi_i     (mthi),
    .mtlo_i     (mtlo),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .md_done_o  (md_done),
    .div_zero_o (div_zero),
    .hi_o       (hi),
    .lo_o       (lo)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32, default latencies).
module tb_seq_alu;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  OR_ = 5'd2,  AND_ = 5'd3;
  localparam logic [4:0] SLT = 5'd4,  SLTU = 5'd5, XOR_ = 5'd6, NOR_ = 5'd7;
  localparam logic [4:0] SLL = 5'd8,  SRL = 5'd9,  SRA = 5'd10, LUI = 5'd11;
  localparam logic [4:0] MULT = 5'd16, MULTU = 5'd17, DIV = 5'd18, DIVU = 5'd19;
  localparam logic [4:0] MTHI = 5'd20, MTLO = 5'd21, UNDEF = 5'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  op;
  logic [31:0] a, b, result, hi, lo;
  logic        res_valid, overflow, busy, md_done, div_zero;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  seq_alu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .a(a), .b(b), .result(result), .res_valid(res_valid),
    .overflow(overflow), .busy(busy), .md_done(md_done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; afterwards outputs reflect cycle N+1.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    req_valid = 1'b1; op = o; a = x; b = y;
    tick();
    req_valid = 1'b0; op = ADD; a = '0; b = '0;
  endtask

  task automatic md_run(input int unsigned lat, input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz);
    for (int unsigned k = 1; k <= lat; k++) begin
      check("md_busy", busy, 1'b1);
      check("md_ready", req_ready, 1'b0);
      check("md_done", md_done, k == lat);
      if (k < lat) begin
        check("hi_hold", hi, old_hi);
        check("lo_hold", lo, old_lo);
        check("dz_clr", div_zero, 1'b0);
      end else begin
        check("md_hi", hi, exp_hi);
        check("md_lo", lo, exp_lo);
        check("md_dz", div_zero, exp_dz);
      end
      tick();
    end
    check("busy_fall", busy, 1'b0);
    check("done_pulse", md_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; op = ADD; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 32'h0);
    check("rst_rv", res_valid, 1'b0);
    check("rst_ov", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", md_done, 1'b0);
    check("rst_dz", div_zero, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset = 1'b0;
    tick();
    check("rst_ready", req_ready, 1'b1);

    // Add/sub and overflow
    issue(ADD, 32'h7FFF_FFFF, 32'h1);
    check("add_res", result, 32'h8000_0000); check("add_ov", overflow, 1'b1); check("add_rv", res_valid, 1'b1);
    issue(SUB, 32'h8000_0000, 32'h1);
    check("sub_res", result, 32'h7FFF_FFFF); check("sub_ov", overflow, 1'b1);
    issue(ADD, 32'h1, 32'h2);
    check("add2_res", result, 32'h3); check("add2_ov", overflow, 1'b0);
    issue(SUB, 32'h5, 32'h7);
    check("sub2_res", result, 32'hFFFF_FFFE); check("sub2_ov", overflow, 1'b0);
    tick();
    check("rv_pulse", res_valid, 1'b0);

    // Multiply
    issue(MULT, 32'hFFFF_FFFD, 32'h7);
    md_run(5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    issue(MULTU, 32'hFFFF_FFFD, 32'h7);
    md_run(5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'h6, 32'hFFFF_FFEB, 1'b0);

    // Divide
    issue(DIV, 32'hFFFF_FFF9, 32'h2);
    md_run(10, 32'h6, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(DIV, 32'h5, 32'h0);
    md_run(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 1'b1);
    tick();
    check("dz_sticky", div_zero, 1'b1);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    md_run(10, 32'h5, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    issue(DIVU, 32'd100, 32'd7);
    md_run(10, 32'h0, 32'h8000_0000, 32'h2, 32'hE, 1'b0);
    issue(DIVU, 32'hFFFF_FFF9, 32'h2);
    md_run(10, 32'h2, 32'hE, 32'h1, 32'h7FFF_FFFC, 1'b0);

    // MTHI / MTLO
    issue(MTHI, 32'hAAAA_5555, 32'h0);
    check("mthi_hi", hi, 32'hAAAA_5555); check("mthi_lo", lo, 32'h7FFF_FFFC);
    check("mthi_rv", res_valid, 1'b0); check("mthi_busy", busy, 1'b0);
    issue(MTLO, 32'h1234_5678, 32'h0);
    check("mtlo_lo", lo, 32'h1234_5678); check("mtlo_hi", hi, 32'hAAAA_5555);

    // Requests ignored while busy; accepted when busy falls
    issue(DIV, 32'd20, 32'd3);
    for (int unsigned k = 1; k <= 10; k++) begin
      check("ign_busy", busy, 1'b1);
      check("ign_ready", req_ready, 1'b0);
      check("ign_rv", res_valid, 1'b0);
      if (k < 10) check("ign_lo_hold", lo, 32'h1234_5678);
      else begin
        check("ign_done", md_done, 1'b1);
        check("ign_lo", lo, 32'h6);
        check("ign_hi", hi, 32'h2);
      end
      req_valid = 1'b1;
      op = k[0] ? ADD : MTLO;
      a = 32'hDEAD_0000 + k;
      b = 32'h1;
      tick();
    end
    check("ign_lo_after", lo, 32'h6);
    check("ign_rv_after", res_valid, 1'b0);
    check("fall_ready", req_ready, 1'b1);
    op = ADD; a = 32'h2; b = 32'h3;
    tick();
    req_valid = 1'b0;
    check("fall_rv", res_valid, 1'b1);
    check("fall_res", result, 32'h5);

    // Reset in the middle of a multiply
    issue(MULT, 32'hFFFF_FFFD, 32'h7);
    tick(); tick();
    check("mid_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_done", md_done, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("post_rst_ready", req_ready, 1'b1);
    issue(MULTU, 32'h2, 32'h3);
    md_run(5, 32'h0, 32'h0, 32'h0, 32'h6, 1'b0);

    // Shifts, LUI, compares, logic, undefined opcode
    issue(SRA, 32'h8000_0000, 32'd31);  check("sra", result, 32'hFFFF_FFFF);
    issue(SRL, 32'h8000_0000, 32'd31);  check("srl", result, 32'h1);
    issue(SLL, 32'h1, 32'h24);          check("sll", result, 32'h10);
    issue(LUI, 32'h0, 32'hFFFF_1234);   check("lui", result, 32'h1234_0000);
    issue(SLTU, 32'h1, 32'hFFFF_FFFF);  check("sltu", result, 32'h1);
    issue(SLT, 32'h1, 32'hFFFF_FFFF);   check("slt", result, 32'h0);
    issue(SLT, 32'hFFFF_FFFF, 32'h1);   check("slt_neg", result, 32'h1);
    issue(XOR_, 32'hF0F0, 32'hFF00);    check("xor", result, 32'h0FF0);
    issue(OR_, 32'hF0, 32'h0F);         check("or", result, 32'hFF);
    issue(AND_, 32'hF0, 32'h3C);        check("and", result, 32'h30);
    issue(ADD, 32'h7FFF_FFFF, 32'h1);   check("ov_set", overflow, 1'b1);
    issue(NOR_, 32'h0, 32'h0);          check("nor", result, 32'hFFFF_FFFF); check("nor_ov", overflow, 1'b0);
    issue(UNDEF, 32'h55, 32'hAA);
    check("undef_res", result, 32'h0); check("undef_rv", res_valid, 1'b1);
    check("undef_busy", busy, 1'b0);   check("undef_hi", hi, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
